// File: rtl/dmem_arb_pkg.sv
// Shared types, memop codes and helpers for the data-memory arbiter.
// Statistics counters in dmem_arbiter are built only when DMEM_ARB_STATS_EN is defined.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        M_CORE = 1'b0,
        M_DBG  = 1'b1
    } master_id_t;

    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LH  = 3'b001;
    localparam logic [2:0] MEMOP_LW  = 3'b010;
    localparam logic [2:0] MEMOP_LBU = 3'b100;
    localparam logic [2:0] MEMOP_LHU = 3'b101;

    // Wide enough for RD_LAT-1 with RD_LAT up to 4.
    localparam int CNT_W = 2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins; on a tie the requester
// that was not granted most recently wins. The pointer moves on every grant.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt_onehot
);

    // Index of the most recent grant; reset to 1 so the core wins the first tie.
    logic last;

    always_comb begin
        gnt_onehot = 2'b00;
        case (req)
            2'b01:   gnt_onehot = 2'b01;
            2'b10:   gnt_onehot = 2'b10;
            2'b11:   gnt_onehot = last ? 2'b01 : 2'b10;
            default: gnt_onehot = 2'b00;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (upd && (req != 2'b00)) begin
            last <= gnt_onehot[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the core (m0) and the debug/loader port (m1).
// Define DMEM_ARB_STATS_EN to add saturating grant and conflict counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [2:0]    m0_op,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [2:0]    m1_op,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [2:0]    mem_op,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_m0_cnt,
    output logic [15:0]   stat_m1_cnt,
    output logic [15:0]   stat_conflict
`endif
);

    // Handshake: a master holds req and its fields stable until it sees a one-cycle
    // gnt; dropping req earlier withdraws the request. A load returns exactly one
    // rvalid pulse RD_LAT cycles after its gnt; stores return nothing.

    arb_state_t       state, state_next;
    master_id_t       owner;
    master_id_t       pick;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       req_vec;
    logic [1:0]       gnt_oh;
    logic             decide;
    logic             rd_done;
    logic             we_q;
    logic [2:0]       op_q;
    logic [AW-1:0]    addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      m0_rdata_q;
    logic [31:0]      m1_rdata_q;

    assign req_vec = {m1_req, m0_req};
    assign decide  = (state == IDLE) && (gnt_oh != 2'b00);
    assign pick    = gnt_oh[1] ? M_DBG : M_CORE;
    assign rd_done = (state == RD_WAIT) && (cnt == '0);

    rr_arbiter2 u_rr (
        .clock      (clock),
        .reset      (reset),
        .req        (req_vec),
        .upd        (decide),
        .gnt_onehot (gnt_oh)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_vec != 2'b00) state_next = ISSUE;
            ISSUE:   state_next = we_q ? IDLE : RD_WAIT;
            RD_WAIT: if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Issue registers hold the last access so the dmem pins stay quiet between accesses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner      <= M_CORE;
            cnt        <= '0;
            we_q       <= 1'b0;
            op_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
        end else begin
            if (decide) begin
                owner   <= pick;
                we_q    <= (pick == M_DBG) ? m1_we    : m0_we;
                op_q    <= (pick == M_DBG) ? m1_op    : m0_op;
                addr_q  <= (pick == M_DBG) ? m1_addr  : m0_addr;
                wdata_q <= (pick == M_DBG) ? m1_wdata : m0_wdata;
            end
            if ((state == ISSUE) && !we_q) begin
                cnt <= CNT_W'(RD_LAT - 1);
            end else if ((state == RD_WAIT) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (rd_done && (owner == M_CORE)) m0_rdata_q <= mem_rdata;
            if (rd_done && (owner == M_DBG))  m1_rdata_q <= mem_rdata;
        end
    end

    assign mem_en    = (state == ISSUE);
    assign mem_we    = we_q;
    assign mem_op    = op_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign m0_gnt    = mem_en && (owner == M_CORE);
    assign m1_gnt    = mem_en && (owner == M_DBG);
    assign m0_rvalid = rd_done && (owner == M_CORE);
    assign m1_rvalid = rd_done && (owner == M_DBG);

    // Return data is forwarded in the rvalid cycle, then held from the capture register.
    assign m0_rdata  = m0_rvalid ? mem_rdata : m0_rdata_q;
    assign m1_rdata  = m1_rvalid ? mem_rdata : m1_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_m0_cnt   <= 16'd0;
            stat_m1_cnt   <= 16'd0;
            stat_conflict <= 16'd0;
        end else if (decide) begin
            if (pick == M_CORE) stat_m0_cnt <= sat_inc16(stat_m0_cnt);
            else                stat_m1_cnt <= sat_inc16(stat_m1_cnt);
            if (req_vec == 2'b11) stat_conflict <= sat_inc16(stat_conflict);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 runs RD_LAT=1, instance 1 runs RD_LAT=3,
// each with its own behavioural dmem; directed scenarios plus a randomized run.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clock;
  logic reset;
  logic [1:0]       m0_req, m0_we, m1_req, m1_we;
  logic [1:0][2:0]  m0_op, m1_op;
  logic [1:0][31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_en, mem_we;
  logic [1:0][31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0][2:0]  mem_op;
`ifdef DMEM_ARB_STATS_EN
  logic [1:0][15:0] stat_m0_cnt, stat_m1_cnt, stat_conflict;
`endif
  logic [31:0] pipe [2][4];
  int n_checks;
  int n_fail;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(.AW(32), .RD_LAT(g == 0 ? 1 : 3)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .m0_req    (m0_req[g]),
      .m0_we     (m0_we[g]),
      .m0_op     (m0_op[g]),
      .m0_addr   (m0_addr[g]),
      .m0_wdata  (m0_wdata[g]),
      .m0_gnt    (m0_gnt[g]),
      .m0_rvalid (m0_rvalid[g]),
      .m0_rdata  (m0_rdata[g]),
      .m1_req    (m1_req[g]),
      .m1_we     (m1_we[g]),
      .m1_op     (m1_op[g]),
      .m1_addr   (m1_addr[g]),
      .m1_wdata  (m1_wdata[g]),
      .m1_gnt    (m1_gnt[g]),
      .m1_rvalid (m1_rvalid[g]),
      .m1_rdata  (m1_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_op    (mem_op[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_m0_cnt   (stat_m0_cnt[g]),
      .stat_m1_cnt   (stat_m1_cnt[g]),
      .stat_conflict (stat_conflict[g])
`endif
    );
  end

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- dmem model: ROM contents, data valid RD_LAT cycles after mem_en ----------------
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? mem_f(mem_addr[k]) : $urandom;
      for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  // ---------------- driver tasks ----------------
  task automatic drive_master(input int k, input int m, input logic req, input logic we,
                              input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req[k] = req; m0_we[k] = we; m0_op[k] = op; m0_addr[k] = addr; m0_wdata[k] = wdata;
    end else begin
      m1_req[k] = req; m1_we[k] = we; m1_op[k] = op; m1_addr[k] = addr; m1_wdata[k] = wdata;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_master(k, 0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      drive_master(k, 1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    @(negedge clock);
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_en[k], mem_we[k]} !== 6'd0) begin
          n_fail++;
          $display("FAIL reset_ctrl dut%0d pass%0d got %b exp 000000", k, pass,
                   {m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_en[k], mem_we[k]});
        end
        n_checks++;
        if ({m0_rdata[k], m1_rdata[k], mem_addr[k], mem_wdata[k], mem_op[k]} !== '0) begin
          n_fail++;
          $display("FAIL reset_data dut%0d pass%0d got %h %h %h %h %h exp all 0", k, pass,
                   m0_rdata[k], m1_rdata[k], mem_addr[k], mem_wdata[k], mem_op[k]);
        end
      end
      reset = 1'b1;
      @(negedge clock);
    end
  endtask

  task automatic test_load_basic();
    drive_master(0, 0, 1'b1, 1'b0, MEMOP_LW, 32'h10, 32'h0);
    @(negedge clock);
    n_checks++;
    if ({m1_gnt[0], m0_gnt[0], mem_en[0], mem_we[0], mem_op[0], mem_addr[0]} !== {1'b0, 1'b1, 1'b1, 1'b0, MEMOP_LW, 32'h10}) begin
      n_fail++;
      $display("FAIL load_gnt got m1g=%b m0g=%b en=%b we=%b op=%b addr=%h exp 0 1 1 0 010 00000010",
               m1_gnt[0], m0_gnt[0], mem_en[0], mem_we[0], mem_op[0], mem_addr[0]);
    end
    drive_master(0, 0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clock);
    n_checks++;
    if ({m0_rvalid[0], m1_rvalid[0], mem_en[0], m0_rdata[0]} !== {3'b100, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL load_rvalid got rv0=%b rv1=%b en=%b rdata=%h exp 1 0 0 deadbeef",
               m0_rvalid[0], m1_rvalid[0], mem_en[0], m0_rdata[0]);
    end
    @(negedge clock);
    n_checks++;
    if ({m0_rvalid[0], m0_rdata[0]} !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL load_hold got rv0=%b rdata=%h exp 0 deadbeef", m0_rvalid[0], m0_rdata[0]);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    drive_master(0, 0, 1'b1, 1'b1, 3'b010, 32'h100, 32'h11111111);
    drive_master(0, 1, 1'b1, 1'b1, 3'b001, 32'h202, 32'h00002222);
    @(negedge clock);
    n_checks++;
    if ({m1_gnt[0], m0_gnt[0], mem_we[0], mem_addr[0], mem_wdata[0]} !== {3'b011, 32'h100, 32'h11111111}) begin
      n_fail++;
      $display("FAIL conflict_first got m1g=%b m0g=%b we=%b addr=%h wdata=%h exp 0 1 1 00000100 11111111",
               m1_gnt[0], m0_gnt[0], mem_we[0], mem_addr[0], mem_wdata[0]);
    end
    drive_master(0, 0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clock);
    n_checks++;
    if ({m1_gnt[0], m0_gnt[0], mem_en[0], mem_addr[0]} !== {3'b000, 32'h100}) begin
      n_fail++;
      $display("FAIL conflict_idle got m1g=%b m0g=%b en=%b addr=%h exp 0 0 0 00000100",
               m1_gnt[0], m0_gnt[0], mem_en[0], mem_addr[0]);
    end
    @(negedge clock);
    n_checks++;
    if ({m1_gnt[0], m0_gnt[0], mem_op[0], mem_addr[0], mem_wdata[0]} !== {2'b10, 3'b001, 32'h202, 32'h00002222}) begin
      n_fail++;
      $display("FAIL conflict_second got m1g=%b m0g=%b op=%b addr=%h wdata=%h exp 1 0 001 00000202 00002222",
               m1_gnt[0], m0_gnt[0], mem_op[0], mem_addr[0], mem_wdata[0]);
    end
    drive_master(0, 1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int g0, last_t, exp_gap, exp_m;
    logic [31:0] a0, a1, exp_addr;
    a0 = 32'h1000; a1 = 32'h2000;
    g0 = 0; last_t = 0; exp_gap = 1; exp_m = 0;   // last grant was m1, so m0 leads
    drive_master(0, 0, 1'b1, 1'b1, 3'b010, a0, $urandom);
    drive_master(0, 1, 1'b1, 1'b1, 3'b010, a1, $urandom);
    for (int t = 1; t <= 40 && g0 < 6; t++) begin
      @(negedge clock);
      if (m0_gnt[0] || m1_gnt[0]) begin
        exp_addr = (exp_m == 0) ? a0 : a1;
        n_checks++;
        if ({m1_gnt[0], m0_gnt[0], mem_addr[0]} !== {((exp_m == 0) ? 2'b01 : 2'b10), exp_addr}) begin
          n_fail++;
          $display("FAIL b2b_order t=%0d got m1g=%b m0g=%b addr=%h exp master %0d addr %h",
                   t, m1_gnt[0], m0_gnt[0], mem_addr[0], exp_m, exp_addr);
        end
        n_checks++;
        if (t - last_t != exp_gap) begin
          n_fail++;
          $display("FAIL b2b_gap t=%0d got gap %0d exp %0d", t, t - last_t, exp_gap);
        end
        if (m0_gnt[0]) begin
          g0++;
          a0 = a0 + 32'd4;
          drive_master(0, 0, (g0 < 6), 1'b1, 3'b010, a0, $urandom);
        end
        if (m1_gnt[0]) begin
          a1 = a1 + 32'd4;
          drive_master(0, 1, 1'b1, 1'b1, 3'b010, a1, $urandom);
        end
        exp_m = 1 - exp_m;
        last_t = t;
        exp_gap = 2;
      end
    end
    n_checks++;
    if (g0 != 6) begin
      n_fail++;
      $display("FAIL b2b_timeout got %0d m0 grants exp 6", g0);
    end
    drive_master(0, 1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clock);
  endtask

  task automatic test_lat3();
    drive_master(1, 1, 1'b1, 1'b0, MEMOP_LBU, 32'h3, 32'h0);
    @(negedge clock);
    n_checks++;
    if ({m1_gnt[1], m0_gnt[1], mem_op[1], mem_addr[1]} !== {2'b10, MEMOP_LBU, 32'h3}) begin
      n_fail++;
      $display("FAIL lat3_gnt got m1g=%b m0g=%b op=%b addr=%h exp 1 0 100 00000003",
               m1_gnt[1], m0_gnt[1], mem_op[1], mem_addr[1]);
    end
    drive_master(1, 1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clock);
      n_checks++;
      if ({m1_rvalid[1], mem_en[1]} !== {(i == 4), 1'b0}) begin
        n_fail++;
        $display("FAIL lat3_wait gnt+%0d got rv1=%b en=%b exp %b 0", i - 1, m1_rvalid[1], mem_en[1], (i == 4));
      end
      if (i == 4) begin
        n_checks++;
        if (m1_rdata[1] !== mem_f(32'h3)) begin
          n_fail++;
          $display("FAIL lat3_data got %h exp %h", m1_rdata[1], mem_f(32'h3));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_master(1, 0, 1'b1, 1'b0, MEMOP_LW, 32'h40, 32'h0);
    @(negedge clock);
    n_checks++;
    if (m0_gnt[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_gnt got %b exp 1", m0_gnt[1]);
    end
    drive_master(1, 0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({m0_gnt[1], m1_gnt[1], m0_rvalid[1], m1_rvalid[1], mem_en[1], m0_rdata[1], m1_rdata[1], mem_addr[1]} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear got g=%b%b rv=%b%b en=%b rd0=%h rd1=%h addr=%h exp all 0",
               m0_gnt[1], m1_gnt[1], m0_rvalid[1], m1_rvalid[1], mem_en[1], m0_rdata[1], m1_rdata[1], mem_addr[1]);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_checks++;
      if ({m0_rvalid[1], m1_rvalid[1], mem_en[1]} !== 3'b000) begin
        n_fail++;
        $display("FAIL rstmid_quiet cyc%0d got rv=%b%b en=%b exp 000", i, m0_rvalid[1], m1_rvalid[1], mem_en[1]);
      end
    end
  endtask

  // Transaction-level model: an idle arbiter decides on the inputs of cycle c,
  // gnt shows at c+1, load data at c+1+lat, next decision at c+2 (store) or c+2+lat (load).
  task automatic test_random(input int k, input int n);
    int lat, free_at, iss_c, rv_c, last, iss_m, rv_m, w;
    logic hold[2];
    logic h_we[2];
    logic [2:0] h_op[2];
    logic [31:0] h_addr[2], h_wdata[2];
    logic iss_we;
    logic [2:0] iss_op;
    logic [31:0] iss_addr, iss_wdata;
    logic [31:0] lst_addr, lst_wdata;
    logic [2:0] lst_op;
    logic [31:0] lst_rdata[2];
    logic [31:0] exp_q[$];
    logic exp_en, dropped;
    logic [1:0] exp_g, exp_rv;
    lat = (k == 0) ? 1 : 3;
    do_reset();
    free_at = 0; iss_c = -1; rv_c = -1; last = 1; iss_m = 0; rv_m = 0;
    iss_we = 1'b0; iss_op = 3'b000; iss_addr = 32'h0; iss_wdata = 32'h0;
    lst_addr = 32'h0; lst_wdata = 32'h0; lst_op = 3'b000;
    for (int m = 0; m < 2; m++) begin
      hold[m] = 1'b0; h_we[m] = 1'b0; h_op[m] = 3'b000; h_addr[m] = 32'h0; h_wdata[m] = 32'h0;
      lst_rdata[m] = 32'h0;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      exp_en = (c == iss_c);
      exp_g = 2'b00;
      if (exp_en) begin
        exp_g[iss_m] = 1'b1;
        lst_addr = iss_addr; lst_wdata = iss_wdata; lst_op = iss_op;
      end
      exp_rv = 2'b00;
      if (c == rv_c) begin
        exp_rv[rv_m] = 1'b1;
        lst_rdata[rv_m] = exp_q.pop_front();
      end
      n_checks++;
      if ({mem_en[k], m1_gnt[k], m0_gnt[k], m1_rvalid[k], m0_rvalid[k]} !== {exp_en, exp_g, exp_rv}) begin
        n_fail++;
        $display("FAIL rnd%0d_ctrl c=%0d got en=%b gnt=%b%b rv=%b%b exp en=%b gnt=%b rv=%b",
                 k, c, mem_en[k], m1_gnt[k], m0_gnt[k], m1_rvalid[k], m0_rvalid[k], exp_en, exp_g, exp_rv);
      end
      n_checks++;
      if ({mem_addr[k], mem_wdata[k], mem_op[k]} !== {lst_addr, lst_wdata, lst_op}) begin
        n_fail++;
        $display("FAIL rnd%0d_bus c=%0d got addr=%h wdata=%h op=%b exp %h %h %b",
                 k, c, mem_addr[k], mem_wdata[k], mem_op[k], lst_addr, lst_wdata, lst_op);
      end
      if (exp_en) begin
        n_checks++;
        if (mem_we[k] !== iss_we) begin
          n_fail++;
          $display("FAIL rnd%0d_we c=%0d got %b exp %b", k, c, mem_we[k], iss_we);
        end
      end
      n_checks++;
      if ({m0_rdata[k], m1_rdata[k]} !== {lst_rdata[0], lst_rdata[1]}) begin
        n_fail++;
        $display("FAIL rnd%0d_rdata c=%0d got %h %h exp %h %h",
                 k, c, m0_rdata[k], m1_rdata[k], lst_rdata[0], lst_rdata[1]);
      end
      for (int m = 0; m < 2; m++) begin
        dropped = 1'b0;
        if (exp_g[m]) begin
          hold[m] = 1'b0;
        end else if (hold[m] && $urandom_range(0, 7) == 0) begin
          hold[m] = 1'b0;
          dropped = 1'b1;
        end
        if (!hold[m] && !dropped && $urandom_range(0, 1) == 1) begin
          hold[m] = 1'b1;
          h_we[m] = 1'($urandom_range(0, 1));
          if (h_we[m]) begin
            h_op[m] = 3'($urandom_range(0, 2));
          end else begin
            case ($urandom_range(0, 4))
              0:       h_op[m] = MEMOP_LB;
              1:       h_op[m] = MEMOP_LH;
              2:       h_op[m] = MEMOP_LW;
              3:       h_op[m] = MEMOP_LBU;
              default: h_op[m] = MEMOP_LHU;
            endcase
          end
          h_addr[m] = $urandom;
          h_wdata[m] = $urandom;
        end
        if (hold[m]) drive_master(k, m, 1'b1, h_we[m], h_op[m], h_addr[m], h_wdata[m]);
        else         drive_master(k, m, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
      end
      if (c >= free_at && (hold[0] || hold[1])) begin
        if (hold[0] && hold[1]) w = 1 - last;
        else                    w = hold[0] ? 0 : 1;
        last = w;
        iss_c = c + 1; iss_m = w;
        iss_we = h_we[w]; iss_op = h_op[w]; iss_addr = h_addr[w]; iss_wdata = h_wdata[w];
        if (h_we[w]) begin
          free_at = c + 2;
        end else begin
          rv_c = c + 1 + lat; rv_m = w;
          exp_q.push_back(mem_f(h_addr[w]));
          free_at = c + 2 + lat;
        end
      end
    end
    drive_master(k, 0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive_master(k, 1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (6) @(negedge clock);
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    int g0, g1;
    g0 = 0; g1 = 0;
    do_reset();
    drive_master(0, 0, 1'b1, 1'b1, 3'b010, 32'h3000, 32'h1);
    drive_master(0, 1, 1'b1, 1'b1, 3'b010, 32'h4000, 32'h2);
    for (int t = 0; t < 60 && g0 < 5; t++) begin
      @(negedge clock);
      if (m0_gnt[0]) g0++;
      if (m1_gnt[0]) g1++;
      drive_master(0, 0, (g0 < 5), 1'b1, 3'b010, 32'h3000 + 32'(g0 * 4), 32'h1);
      drive_master(0, 1, (g0 < 2), 1'b1, 3'b010, 32'h4000, 32'h2);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if ({stat_m0_cnt[0], stat_m1_cnt[0], stat_conflict[0]} !== {16'd5, 16'd1, 16'd3}) begin
      n_fail++;
      $display("FAIL stats got m0=%0d m1=%0d conflict=%0d exp 5 1 3",
               stat_m0_cnt[0], stat_m1_cnt[0], stat_conflict[0]);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    test_reset();
    test_load_basic();
    test_conflict();
    test_back_to_back();
    test_lat3();
    test_reset_mid();
    test_random(0, 600);
    test_random(1, 600);
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
